systolic_sequencer: RTL

- Controller that sequences one job on the 8x8 bit-level systolic OR-accumulate array.
- Per job: clears the array, then streams a host-supplied number of operand pairs over a valid/ready handshake, inserting zero bubble cycles after each pair.
- Then flushes the pipeline, pulses readout, captures the N result rows into a local buffer and drains them over a valid/ready result port.
- Sits between the chip I/O front end and the array; it replaces the free-running input alternation logic.

---
 rtl/systolic_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/systolic_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_sequencer
//
// Runs one job on the N x N bit-level systolic OR-accumulate array:
//   IDLE -> CLEAR -> LOAD -> FLUSH -> READOUT -> DRAIN -> IDLE
// The array is cleared, the host-supplied number of operand pairs is
// streamed in with BUBBLE zero cycles after each pair, the pipeline is
// flushed with zeros, the N result rows are captured into a local buffer
// during readout, and the buffer is then drained over the result port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len            job request and pair count (sampled in IDLE)
//   busy, done            job in progress, one-cycle completion pulse
//   in_valid/in_ready     operand pair handshake, data on in_a/in_b
//   arr_in1, arr_in2      registered operand drive to the array
//   arr_clear             synchronous clear to the array
//   arr_readout           array readout select
//   arr_out               array bottom-row output
//   res_valid/res_ready   result handshake, data on res_data/res_last
//   dbg_state             current FSM state for observation
//
// Handshakes (both ports): a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. A producer never drops
// valid or changes data without a transfer; ready may not depend on
// valid. in_ready and res_valid decode from registered state only.
// ---------------------------------------------------------------------------
module systolic_sequencer #(
  parameter int N            = 8,
  parameter int LEN_W        = 8,
  parameter int BUBBLE       = 1,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N-1:0]     arr_in1,
  output logic [N-1:0]     arr_in2,
  output logic             arr_clear,
  output logic             arr_readout,
  input  logic [N-1:0]     arr_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_last,
  output logic [2:0]       dbg_state
);

  localparam int CNT_NEED = $clog2(FLUSH_CYCLES + N + 1);
  localparam int CNT_W    = (CNT_NEED > 6) ? CNT_NEED : 6;
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LOAD    = 3'd2,
    FLUSH   = 3'd3,
    READOUT = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q;
  logic [1:0]         bubble_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N-1:0]       row_buf [N];
  logic [N-1:0]       arr_in1_q, arr_in2_q;
  logic               busy_q, done_q, clear_q, readout_q;
  logic               accept, res_hs, last_idx;

  // Handshake decode, from registered state only.
  assign in_ready  = (state_q == LOAD) && (remaining_q != '0) && (bubble_q == 2'd0);
  assign accept    = in_valid && in_ready;
  assign res_valid = (state_q == DRAIN);
  assign last_idx  = (idx_q == IDX_W'(N - 1));
  assign res_last  = res_valid && last_idx;
  assign res_data  = res_valid ? row_buf[idx_q] : '0;
  assign res_hs    = res_valid && res_ready;

  assign busy        = busy_q;
  assign done        = done_q;
  assign arr_clear   = clear_q;
  assign arr_readout = readout_q;
  assign arr_in1     = arr_in1_q;
  assign arr_in2     = arr_in2_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (remaining_q == '0) ? FLUSH : LOAD;
      // Leave once every pair is in and the bubble count reaches zero on
      // this edge; the final bubble cycle therefore coincides with the
      // first flush cycle. The !accept term keeps a data cycle out of
      // FLUSH when BUBBLE is 0.
      LOAD:    if (!accept && (remaining_q == '0) && (bubble_q <= 2'd1))
                 state_d = FLUSH;
      FLUSH:   if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) state_d = READOUT;
      READOUT: if (cnt_q == CNT_W'(N)) state_d = DRAIN;
      DRAIN:   if (res_hs && last_idx) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      bubble_q    <= 2'd0;
      cnt_q       <= '0;
      idx_q       <= '0;
      arr_in1_q   <= '0;
      arr_in2_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b0;
      readout_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= res_hs && last_idx;
      clear_q   <= (state_d == CLEAR);
      readout_q <= (state_d == READOUT);
      // Operands reach the array only in the cycle after an accept.
      arr_in1_q <= accept ? in_a : '0;
      arr_in2_q <= accept ? in_b : '0;

      if (state_q == IDLE && start)
        remaining_q <= len;
      else if (accept)
        remaining_q <= remaining_q - 1'b1;

      if (accept)
        bubble_q <= 2'(BUBBLE);
      else if (bubble_q != 2'd0)
        bubble_q <= bubble_q - 1'b1;

      // Shared phase counter: restarts on every state change and only
      // runs in the timed states.
      if ((state_d != state_q) || !(state_q inside {FLUSH, READOUT}))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;

      if (state_q != DRAIN)
        idx_q <= '0;
      else if (res_hs)
        idx_q <= idx_q + 1'b1;
    end
  end

  // Result buffer: contents are don't-care until written, so no reset.
  // Readout cycle 0 is the array's select latency and is skipped.
  always_ff @(posedge clk) begin
    if (state_q == READOUT && cnt_q != '0)
      row_buf[IDX_W'(cnt_q - 1'b1)] <= arr_out;
  end

endmodule
